// File: rtl/cache_burst_responder.sv
// cache_burst_responder
// Bridges a cache line-fill port onto a 16-bit single-word memory port.
// A read fetches four words into a line buffer. The words are then
// streamed back on four consecutive cycles, with sdram_fill marking the
// first one. A write performs one memory cycle and then pulses sdram_wrack.
// Optional feature macro: CRITICAL_WORD_FIRST_EN. When it is defined, the
// burst starts at the requested word (sdram_addr[2:1]); otherwise the burst
// starts at word 0.
// Handshake on the memory side: mem_req rises with a valid mem_addr,
// mem_we, mem_be_n and mem_wdata, and holds them stable until the cycle in
// which mem_ack is high. That cycle completes the word, and mem_rdata is
// sampled in it.
module cache_burst_responder #(
  parameter int MEM_AW = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       sdram_addr,
  input  logic              sdram_req,
  input  logic              sdram_rw,
  input  logic              sdram_wru,
  input  logic              sdram_wrl,
  input  logic [15:0]       data_to_sdram,
  output logic [15:0]       data_from_sdram,
  output logic              sdram_fill,
  output logic              sdram_wrack,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_be_n,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RDFETCH  = 3'd1,
    RDSTREAM = 3'd2,
    WRITE    = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  state_t            state, next_state;
  logic [MEM_AW-1:0] addr_q;
  logic [1:0]        s_q;
  logic [1:0]        word_cnt;
  logic [1:0]        be_q;
  logic [15:0]       wdata_q;
  logic [15:0]       dout_q;
  logic              fill_q;
  logic              wrack_q;
  logic [15:0]       line_buf [4];
  logic [1:0]        req_start;
  logic [1:0]        fetch_idx;
  logic [1:0]        stream_next;
  logic              unused_addr_bits;

`ifdef CRITICAL_WORD_FIRST_EN
  assign req_start = sdram_addr[2:1];
`else
  assign req_start = 2'b00;
`endif

  // Byte-select bit and address bits above the memory range are not used.
  assign unused_addr_bits = ^{sdram_addr[31:MEM_AW+1], sdram_addr[0]};

  // Word indices wrap modulo 4 because they are 2 bits wide.
  assign fetch_idx   = s_q + word_cnt;
  assign stream_next = s_q + word_cnt + 2'd1;

  assign mem_req         = (state == RDFETCH) || (state == WRITE);
  assign mem_we          = (state == WRITE);
  assign mem_addr        = (state == RDFETCH) ? {addr_q[MEM_AW-1:2], fetch_idx} : addr_q;
  assign mem_be_n        = be_q;
  assign mem_wdata       = wdata_q;
  assign data_from_sdram = dout_q;
  assign sdram_fill      = fill_q;
  assign sdram_wrack     = wrack_q;
  assign dbg_state       = state;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic. RELEASE blocks a held request from starting a new transaction.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (sdram_req) next_state = sdram_rw ? RDFETCH : WRITE;
      RDFETCH:  if (mem_ack && (word_cnt == 2'd3)) next_state = RDSTREAM;
      RDSTREAM: if (word_cnt == 2'd3) next_state = RELEASE;
      WRITE:    if (mem_ack) next_state = RELEASE;
      RELEASE:  if (!sdram_req) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Datapath: request latch, line buffer fill, stream output and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      s_q      <= '0;
      word_cnt <= '0;
      be_q     <= 2'b11;
      wdata_q  <= '0;
      dout_q   <= '0;
      fill_q   <= 1'b0;
      wrack_q  <= 1'b0;
      for (int i = 0; i < 4; i++) line_buf[i] <= '0;
    end else begin
      fill_q  <= 1'b0;
      wrack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (sdram_req) begin
            addr_q   <= sdram_addr[MEM_AW:1];
            s_q      <= req_start;
            word_cnt <= 2'd0;
            be_q     <= {sdram_wru, sdram_wrl};
            wdata_q  <= data_to_sdram;
          end
        end
        RDFETCH: begin
          if (mem_ack) begin
            line_buf[fetch_idx] <= mem_rdata;
            word_cnt            <= word_cnt + 2'd1;
            // The start word was fetched first, so it is already in the buffer.
            if (word_cnt == 2'd3) begin
              fill_q <= 1'b1;
              dout_q <= line_buf[s_q];
            end
          end
        end
        RDSTREAM: begin
          word_cnt <= word_cnt + 2'd1;
          if (word_cnt != 2'd3) dout_q <= line_buf[stream_next];
        end
        WRITE: begin
          if (mem_ack) wrack_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_burst_responder.sv
// Directed bench for cache_burst_responder with a wait-state memory model.
module tb_cache_burst_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_rw;
  logic        sdram_wru;
  logic        sdram_wrl;
  logic [15:0] data_to_sdram;
  logic [15:0] data_from_sdram;
  logic        sdram_fill;
  logic        sdram_wrack;
  logic [23:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_be_n;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int wait_cycles = 0;
  int wait_cnt = 0;
  logic [15:0] exp_q[$];

  // Clock and reset block.
  always #5 clk = ~clk;

  cache_burst_responder #(.MEM_AW(24)) dut (
    .clk(clk), .reset(reset), .sdram_addr(sdram_addr), .sdram_req(sdram_req),
    .sdram_rw(sdram_rw), .sdram_wru(sdram_wru), .sdram_wrl(sdram_wrl),
    .data_to_sdram(data_to_sdram), .data_from_sdram(data_from_sdram),
    .sdram_fill(sdram_fill), .sdram_wrack(sdram_wrack), .mem_addr(mem_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be_n(mem_be_n), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_state(dbg_state)
  );

  // Memory model: word at address a reads as a ^ 0xA000, acks after wait_cycles.
  assign mem_ack   = mem_req && (wait_cnt == wait_cycles);
  assign mem_rdata = mem_addr[15:0] ^ 16'hA000;

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue a read and follow it to the end of the stream. Cycle k is the k-th
  // cycle after the one in which the request is first sampled.
  task automatic run_read(input string tag, input logic [31:0] addr, input int waits,
                          input int drop_k, input logic [95:0] exp_addr,
                          input logic [63:0] exp_data, input int exp_fill_k);
    logic [23:0] seen_addr[$];
    int fill_k;
    int fills;
    int req_cyc;
    fill_k = 0;
    fills = 0;
    req_cyc = 0;
    wait_cycles = waits;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_data[63-16*i -: 16]);
    @(negedge clk);
    sdram_addr = addr;
    sdram_rw   = 1'b1;
    sdram_req  = 1'b1;
    for (int k = 1; k <= exp_fill_k + 10; k++) begin
      @(negedge clk);
      if (k == drop_k) sdram_req = 1'b0;
      if (mem_req) req_cyc++;
      if (mem_req && mem_ack) seen_addr.push_back(mem_addr);
      if (sdram_fill) begin
        fills++;
        if (fill_k == 0) fill_k = k;
      end
      if (fill_k != 0 && k < fill_k + 4 && exp_q.size() > 0)
        check({tag, "_data"}, data_from_sdram, exp_q.pop_front());
    end
    check({tag, "_fill_cycle"}, fill_k, exp_fill_k);
    check({tag, "_fill_count"}, fills, 1);
    check({tag, "_req_cycles"}, req_cyc, 4 * (waits + 1));
    check({tag, "_words_streamed"}, exp_q.size(), 0);
    check({tag, "_addr_count"}, seen_addr.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < seen_addr.size()) check({tag, "_addr"}, seen_addr[i], exp_addr[95-24*i -: 24]);
    check({tag, "_hold_data"}, data_from_sdram, exp_data[15:0]);
    check({tag, "_state_after"}, dbg_state, (drop_k != 0) ? 3'd0 : 3'd4);
    sdram_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_idle"}, dbg_state, 3'd0);
  endtask

  task automatic run_write(input string tag, input logic [31:0] addr, input logic [15:0] wdata,
                           input logic wru, input logic wrl, input int waits,
                           input logic [23:0] exp_addr, input logic [1:0] exp_be);
    int ack_k;
    int wrack_k;
    int wracks;
    int req_cyc;
    logic we_s;
    logic [1:0] be_s;
    logic [23:0] addr_s;
    logic [15:0] wdata_s;
    ack_k = 0;
    wrack_k = 0;
    wracks = 0;
    req_cyc = 0;
    we_s = 1'b0;
    be_s = 2'b00;
    addr_s = '0;
    wdata_s = '0;
    wait_cycles = waits;
    @(negedge clk);
    sdram_addr    = addr;
    sdram_rw      = 1'b0;
    sdram_wru     = wru;
    sdram_wrl     = wrl;
    data_to_sdram = wdata;
    sdram_req     = 1'b1;
    for (int k = 1; k <= waits + 8; k++) begin
      @(negedge clk);
      if (mem_req) req_cyc++;
      if (mem_req && mem_ack) begin
        ack_k = k;
        we_s = mem_we;
        be_s = mem_be_n;
        addr_s = mem_addr;
        wdata_s = mem_wdata;
      end
      if (sdram_wrack) begin
        wracks++;
        if (wrack_k == 0) wrack_k = k;
      end
    end
    check({tag, "_ack_cycle"}, ack_k, waits + 1);
    check({tag, "_wrack_cycle"}, wrack_k, waits + 2);
    check({tag, "_wrack_count"}, wracks, 1);
    check({tag, "_req_cycles"}, req_cyc, waits + 1);
    check({tag, "_we"}, we_s, 1'b1);
    check({tag, "_be_n"}, be_s, exp_be);
    check({tag, "_addr"}, addr_s, exp_addr);
    check({tag, "_wdata"}, wdata_s, wdata);
    sdram_req = 1'b0;
    sdram_wru = 1'b1;
    sdram_wrl = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_idle"}, dbg_state, 3'd0);
  endtask

  initial begin
    int fills;
    int wracks;
    reset = 1'b1;
    sdram_addr = '0;
    sdram_req = 1'b0;
    sdram_rw = 1'b0;
    sdram_wru = 1'b1;
    sdram_wrl = 1'b1;
    data_to_sdram = '0;
    repeat (3) @(negedge clk);
    check("rst_fill", sdram_fill, 1'b0);
    check("rst_wrack", sdram_wrack, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_be_n", mem_be_n, 2'b11);
    check("rst_dout", data_from_sdram, 16'h0);
    check("rst_mem_addr", mem_addr, 24'h0);
    check("rst_wdata", mem_wdata, 16'h0);
    check("rst_state", dbg_state, 3'd0);
    reset = 1'b0;

    run_read("rd100", 32'h100, 0, 0, {24'h80, 24'h81, 24'h82, 24'h83},
             {16'hA080, 16'hA081, 16'hA082, 16'hA083}, 5);
`ifdef CRITICAL_WORD_FIRST_EN
    run_read("rd106", 32'h106, 0, 0, {24'h83, 24'h80, 24'h81, 24'h82},
             {16'hA083, 16'hA080, 16'hA081, 16'hA082}, 5);
`else
    run_read("rd106", 32'h106, 0, 0, {24'h80, 24'h81, 24'h82, 24'h83},
             {16'hA080, 16'hA081, 16'hA082, 16'hA083}, 5);
`endif
    run_read("rd_wait3", 32'h100, 3, 0, {24'h80, 24'h81, 24'h82, 24'h83},
             {16'hA080, 16'hA081, 16'hA082, 16'hA083}, 17);
    run_read("rd_drop", 32'h208, 0, 2, {24'h104, 24'h105, 24'h106, 24'h107},
             {16'hA104, 16'hA105, 16'hA106, 16'hA107}, 5);
    run_write("wr20", 32'h20, 16'hBEEF, 1'b0, 1'b1, 0, 24'h10, 2'b01);
    run_write("wr_nobytes", 32'h40, 16'h1234, 1'b1, 1'b1, 2, 24'h20, 2'b11);

    // Reset during the second word fetch.
    wait_cycles = 1;
    @(negedge clk);
    sdram_addr = 32'h100;
    sdram_rw   = 1'b1;
    sdram_req  = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_fetch_req", mem_req, 1'b1);
    check("rstmid_fetch_addr", mem_addr, 24'h81);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_req_drop", mem_req, 1'b0);
    check("rstmid_state", dbg_state, 3'd0);
    sdram_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    fills = 0;
    wracks = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sdram_fill) fills++;
      if (sdram_wrack) wracks++;
    end
    check("rstmid_no_fill", fills, 0);
    check("rstmid_no_wrack", wracks, 0);
    check("rstmid_dout_clear", data_from_sdram, 16'h0);
    run_read("rd_after_rst", 32'h100, 0, 0, {24'h80, 24'h81, 24'h82, 24'h83},
             {16'hA080, 16'hA081, 16'hA082, 16'hA083}, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
